ecc_dec_pipe: RTL

Multi-lane, pipelined extended-Hamming (SECDED) decoder with a valid/ready stream interface.
- Decodes LANES independent code words per beat.
- Corrects single-bit errors (when enabled) and flags double-bit errors per lane.
- Keeps saturating error statistics and captures the first double-bit error for software.
- Sits between ECC-protected storage or links and downstream consumers. It is the streaming, multi-channel successor of the single-word combinational decoder.

---
 rtl/ecc_dec_pipe.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ecc_dec_pipe.sv
// Multi-lane pipelined SECDED (extended Hamming) decoder with valid/ready streaming,
// saturating error statistics and first-double-error capture.
module ecc_dec_pipe #(
  parameter int K      = 8,
  parameter int LANES  = 2,
  parameter int P0_LSB = 1,
  parameter int CNT_W  = 16,
  localparam int M  = $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1)))),
  localparam int N  = M + K,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clkena_i,
  input  logic                   correct_en_i,
  input  logic [LANES*(N+1)-1:0] d_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [LANES*K-1:0]     q_o,
  output logic [LANES*(M+1)-1:0] syndrome_o,
  output logic [LANES-1:0]       sb_err_o,
  output logic [LANES-1:0]       db_err_o,
  output logic [LANES-1:0]       sb_fix_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CNT_W-1:0]       sb_cnt_o,
  output logic [CNT_W-1:0]       db_cnt_o,
  input  logic                   clr_i,
  output logic                   cap_valid_o,
  output logic [LW-1:0]          cap_lane_o,
  output logic [M:0]             cap_syndrome_o
);

  localparam int PW = $clog2(LANES + 1) + 1;
  localparam logic [M-1:0] NMAX = M'(N);
  localparam logic [N:0]   ONE  = (N+1)'(1);

  // Lane word -> codeword positions 0..N with p0 at position 0.
  function automatic logic [N:0] to_pos(input logic [N:0] w);
    if (P0_LSB != 0) return w;
    return {w[N-1:0], w[N]};
  endfunction

  function automatic logic [M-1:0] calc_syn(input logic [N:0] cw);
    logic [M-1:0] s;
    s = '0;
    for (int i = 1; i <= N; i++)
      if (cw[i]) s = s ^ M'(i);
    return s;
  endfunction

  function automatic logic [K-1:0] extract(input logic [N:0] cw);
    logic [K-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i <= N; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    return d;
  endfunction

  function automatic logic [PW-1:0] popcnt(input logic [LANES-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [PW-1:0] inc);
    logic [CNT_W+PW-1:0] s;
    s = {{PW{1'b0}}, c} + {{CNT_W{1'b0}}, inc};
    if (s > {{PW{1'b0}}, {CNT_W{1'b1}}}) return '1;
    return s[CNT_W-1:0];
  endfunction

  logic [LANES*(N+1)-1:0] cw_p1_q, cw_d;
  logic [LANES*M-1:0]     syn_p1_q, syn_d;
  logic [LANES-1:0]       par_p1_q, par_d;
  logic                   cen_p1_q, vld_p1_q;
  logic [LANES*K-1:0]     q_p2_q, q_d;
  logic [LANES*(M+1)-1:0] so_p2_q, so_d;
  logic [LANES-1:0]       sb_p2_q, sb_d, db_p2_q, db_d, fix_p2_q, fix_d;
  logic                   vld_p2_q;
  logic                   adv2, xfer;
  logic [CNT_W-1:0]       sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;
  logic                   cap_valid_q, cap_valid_d;
  logic [LW-1:0]          cap_lane_q, cap_lane_d;
  logic [M:0]             cap_syn_q, cap_syn_d;

  assign adv2    = !vld_p2_q || ready_i;
  assign ready_o = !vld_p1_q || adv2;
  assign xfer    = vld_p2_q && ready_i && clkena_i;

  // Stage 1 input: reorder, parity and syndrome per lane.
  always_comb begin
    cw_d  = '0;
    par_d = '0;
    syn_d = '0;
    for (int l = 0; l < LANES; l++) begin
      cw_d[l*(N+1) +: N+1] = to_pos(d_i[l*(N+1) +: N+1]);
      par_d[l]             = ^d_i[l*(N+1) +: N+1];
      syn_d[l*M +: M]      = calc_syn(to_pos(d_i[l*(N+1) +: N+1]));
    end
  end

  // Stage 2 input: correction, information extraction and flags.
  always_comb begin
    logic [N:0]   cw;
    logic [M-1:0] s;
    logic         p;
    cw    = '0;
    s     = '0;
    p     = 1'b0;
    q_d   = '0;
    so_d  = '0;
    sb_d  = '0;
    db_d  = '0;
    fix_d = '0;
    for (int l = 0; l < LANES; l++) begin
      cw = cw_p1_q[l*(N+1) +: N+1];
      s  = syn_p1_q[l*M +: M];
      p  = par_p1_q[l];
      // Syndromes beyond N point at no real bit, so nothing is flipped.
      if (cen_p1_q && p && (s <= NMAX)) cw = cw ^ (ONE << s);
      q_d[l*K +: K]       = extract(cw);
      so_d[l*(M+1) +: M+1] = (P0_LSB != 0) ? {s, p} : {p, s};
      sb_d[l]  = p;
      db_d[l]  = !p && (s != '0);
      fix_d[l] = cen_p1_q && p && ((s & (s - M'(1))) != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1_q <= 1'b0;
      cen_p1_q <= 1'b0;
      cw_p1_q  <= '0;
      par_p1_q <= '0;
      syn_p1_q <= '0;
      vld_p2_q <= 1'b0;
      q_p2_q   <= '0;
      so_p2_q  <= '0;
      sb_p2_q  <= '0;
      db_p2_q  <= '0;
      fix_p2_q <= '0;
    end else if (clkena_i) begin
      if (ready_o) begin
        vld_p1_q <= valid_i;
        if (valid_i) begin
          cw_p1_q  <= cw_d;
          par_p1_q <= par_d;
          syn_p1_q <= syn_d;
          cen_p1_q <= correct_en_i;
        end
      end
      if (adv2) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          q_p2_q   <= q_d;
          so_p2_q  <= so_d;
          sb_p2_q  <= sb_d;
          db_p2_q  <= db_d;
          fix_p2_q <= fix_d;
        end
      end
    end
  end

  // Statistics: clear wins over a coincident increment or capture.
  always_comb begin
    sb_cnt_d    = sb_cnt_q;
    db_cnt_d    = db_cnt_q;
    cap_valid_d = cap_valid_q;
    cap_lane_d  = cap_lane_q;
    cap_syn_d   = cap_syn_q;
    if (clr_i) begin
      sb_cnt_d    = '0;
      db_cnt_d    = '0;
      cap_valid_d = 1'b0;
      cap_lane_d  = '0;
      cap_syn_d   = '0;
    end else if (xfer) begin
      sb_cnt_d = sat_add(sb_cnt_q, popcnt(sb_p2_q));
      db_cnt_d = sat_add(db_cnt_q, popcnt(db_p2_q));
      if (!cap_valid_q && (db_p2_q != '0)) begin
        cap_valid_d = 1'b1;
        for (int l = LANES - 1; l >= 0; l--)
          if (db_p2_q[l]) begin
            cap_lane_d = LW'(l);
            cap_syn_d  = so_p2_q[l*(M+1) +: M+1];
          end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sb_cnt_q    <= '0;
      db_cnt_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_lane_q  <= '0;
      cap_syn_q   <= '0;
    end else if (clkena_i) begin
      sb_cnt_q    <= sb_cnt_d;
      db_cnt_q    <= db_cnt_d;
      cap_valid_q <= cap_valid_d;
      cap_lane_q  <= cap_lane_d;
      cap_syn_q   <= cap_syn_d;
    end
  end

  assign valid_o        = vld_p2_q;
  assign q_o            = q_p2_q;
  assign syndrome_o     = so_p2_q;
  assign sb_err_o       = sb_p2_q;
  assign db_err_o       = db_p2_q;
  assign sb_fix_o       = fix_p2_q;
  assign sb_cnt_o       = sb_cnt_q;
  assign db_cnt_o       = db_cnt_q;
  assign cap_valid_o    = cap_valid_q;
  assign cap_lane_o     = cap_lane_q;
  assign cap_syndrome_o = cap_syn_q;

endmodule
